// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES tables, FSM encoding and GF(2^8) helpers
package aes_pkg;

  typedef enum logic [1:0] {
    BOS      = 2'd0,
    GENISLET = 2'd1,
    TUR      = 2'd2,
    CIKIS    = 2'd3
  } fsm_t;

  // Byte 0 of each table sits in the top bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 is unused; key expansion step n uses RCON[n].
  localparam logic [7:0] RCON [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] off;
    off = {~b, 3'b000};
    return SBOX[off +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] off;
    off = {~b, 3'b000};
    return INV_SBOX[off +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         mix_en,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns
  always_comb begin
    shifted   = '0;
    subbed    = '0;
    keyed     = '0;
    state_out = '0;
    // byte (row r, col c) comes from (row r, col c - r)
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(r + 4*c) -: 8] = state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      subbed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]);
    end
    keyed = subbed ^ round_key;
    for (int c = 0; c < 4; c++) begin
      state_out[127 - 32*c -: 32] = mix_en ? inv_mix_col(keyed[127 - 32*c -: 32])
                                           : keyed[127 - 32*c -: 32];
    end
  end

endmodule

// File: rtl/aes_decrypt_engine.sv
// rtl/aes_decrypt_engine.sv - iterative AES-128 decryptor with round-key cache
module aes_decrypt_engine
  import aes_pkg::*;
#(
  parameter bit ANAHTAR_ONBELLEK = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic [127:0] sifre,
  input  logic         g_gecerli,
  output logic         hazir,
  output logic [127:0] blok,
  output logic         c_gecerli,
  input  logic         c_hazir
);

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   cnt_q;
  logic         cache_ok_q;
  logic [127:0] key_q;
  logic [127:0] rk_q [0:10];
  logic [127:0] st_q;
  logic [127:0] blok_q;

  logic         accept;
  logic         key_hit;
  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [127:0] rk_cur;
  logic [31:0]  temp_w;
  logic [127:0] round_out;

  // The cached schedule is reusable only if it was completed for this exact key
  assign key_hit = ANAHTAR_ONBELLEK && cache_ok_q && (anahtar == key_q);
  assign accept  = hazir && g_gecerli;
  assign rk_cur  = rk_q[cnt_q];
  assign blok    = blok_q;

  // One key schedule step: rk[n] from rk[n-1]
  always_comb begin
    rk_prev = rk_q[cnt_q - 4'd1];
    temp_w  = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]), sbox(rk_prev[7:0]),
               sbox(rk_prev[31:24])} ^ {RCON[cnt_q], 24'h000000};
    rk_next[127:96] = rk_prev[127:96] ^ temp_w;
    rk_next[95:64]  = rk_prev[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_prev[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_prev[31:0]   ^ rk_next[63:32];
  end

  aes_inv_round u_inv_round (
    .state_in  (st_q),
    .round_key (rk_cur),
    .mix_en    (cnt_q != 4'd0),
    .state_out (round_out)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= BOS;
    else     fsm_q <= fsm_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    fsm_d     = fsm_q;
    hazir     = 1'b0;
    c_gecerli = 1'b0;
    case (fsm_q)
      BOS: begin
        hazir = 1'b1;
        if (g_gecerli) fsm_d = key_hit ? TUR : GENISLET;
      end
      GENISLET: if (cnt_q == 4'd10) fsm_d = TUR;
      TUR:      if (cnt_q == 4'd0)  fsm_d = CIKIS;
      CIKIS: begin
        c_gecerli = 1'b1;
        if (c_hazir) fsm_d = BOS;
      end
      default: fsm_d = BOS;
    endcase
  end

  // Round counter, key schedule storage, cipher state and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      cache_ok_q <= 1'b0;
      key_q      <= '0;
      st_q       <= '0;
      blok_q     <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      case (fsm_q)
        BOS: begin
          if (accept) begin
            st_q <= sifre;
            if (key_hit) begin
              cnt_q <= 4'd10;
            end else begin
              // schedule is being rebuilt, so it stays invalid until step 10 lands
              key_q      <= anahtar;
              rk_q[0]    <= anahtar;
              cache_ok_q <= 1'b0;
              cnt_q      <= 4'd1;
            end
          end
        end
        GENISLET: begin
          rk_q[cnt_q] <= rk_next;
          if (cnt_q == 4'd10) begin
            cache_ok_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        TUR: begin
          if (cnt_q == 4'd10) begin
            st_q  <= st_q ^ rk_cur;
            cnt_q <= cnt_q - 4'd1;
          end else if (cnt_q == 4'd0) begin
            st_q   <= round_out;
            blok_q <= round_out;
          end else begin
            st_q  <= round_out;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_engine.sv
// tb/tb_aes_decrypt_engine.sv - directed-vector bench for aes_decrypt_engine
module tb_aes_decrypt_engine;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst;
  logic [127:0] anahtar;
  logic [127:0] sifre;
  logic         g_gecerli, g_gecerli2;
  logic         c_hazir, c_hazir2;
  logic         hazir, hazir2;
  logic         c_gecerli, c_gecerli2;
  logic [127:0] blok, blok2;

  int vectors;
  int miscompares;

  aes_decrypt_engine #(.ANAHTAR_ONBELLEK(1'b1)) dut (
    .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre), .g_gecerli(g_gecerli),
    .hazir(hazir), .blok(blok), .c_gecerli(c_gecerli), .c_hazir(c_hazir)
  );

  aes_decrypt_engine #(.ANAHTAR_ONBELLEK(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre), .g_gecerli(g_gecerli2),
    .hazir(hazir2), .blok(blok2), .c_gecerli(c_gecerli2), .c_hazir(c_hazir2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one block through instance sel, measures accept-to-valid clocks, then consumes it.
  task automatic run_block(input bit sel, input logic [127:0] key, input logic [127:0] ct,
                           output int lat, output logic [127:0] pt, output bit hz_bad);
    int n;
    n = 0;
    hz_bad = 1'b0;
    while (!(sel ? hazir2 : hazir) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    anahtar = key;
    sifre   = ct;
    if (sel) g_gecerli2 = 1'b1; else g_gecerli = 1'b1;
    @(posedge clk); #1;
    g_gecerli  = 1'b0;
    g_gecerli2 = 1'b0;
    lat = 0;
    while (!(sel ? c_gecerli2 : c_gecerli) && lat < 100) begin
      if (sel ? hazir2 : hazir) hz_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (sel ? hazir2 : hazir) hz_bad = 1'b1;
    pt = sel ? blok2 : blok;
    if (sel) c_hazir2 = 1'b1; else c_hazir = 1'b1;
    @(posedge clk); #1;
    c_hazir  = 1'b0;
    c_hazir2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (hazir !== 1'b1 || c_gecerli !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: hazir=%b c_gecerli=%b, expected 1 0", hazir, c_gecerli);
    end
    vectors++;
    if (blok !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_blok: got %h, expected 0", blok);
    end
    vectors++;
    if (hazir2 !== 1'b1 || c_gecerli2 !== 1'b0 || blok2 !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_nocache: hazir=%b c_gecerli=%b blok=%h", hazir2, c_gecerli2, blok2);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (hazir !== 1'b1 || c_gecerli !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_idle: hazir=%b c_gecerli=%b, expected 1 0", hazir, c_gecerli);
    end
  endtask

  task automatic test_fips_c1;
    int lat; logic [127:0] pt; bit hz;
    run_block(1'b0, C1_KEY, C1_CT, lat, pt, hz);
    vectors++;
    if (pt !== C1_PT) begin
      miscompares++;
      $display("FAIL c1_plaintext: got %h, expected %h", pt, C1_PT);
    end
    vectors++;
    if (lat !== 21) begin
      miscompares++;
      $display("FAIL c1_latency: got %0d, expected 21", lat);
    end
  endtask

  task automatic test_fips_b;
    int lat; logic [127:0] pt; bit hz;
    run_block(1'b0, B_KEY, B_CT, lat, pt, hz);
    vectors++;
    if (pt !== B_PT) begin
      miscompares++;
      $display("FAIL b_plaintext: got %h, expected %h", pt, B_PT);
    end
    vectors++;
    if (lat !== 21) begin
      miscompares++;
      $display("FAIL b_miss_latency: got %0d, expected 21", lat);
    end
  endtask

  task automatic test_cache;
    int lat; logic [127:0] pt; bit hz;
    run_block(1'b0, B_KEY, B_CT, lat, pt, hz);
    vectors++;
    if (pt !== B_PT) begin
      miscompares++;
      $display("FAIL hit_plaintext: got %h, expected %h", pt, B_PT);
    end
    vectors++;
    if (lat !== 11) begin
      miscompares++;
      $display("FAIL hit_latency: got %0d, expected 11", lat);
    end
    run_block(1'b0, B_KEY ^ 128'h1, B_CT, lat, pt, hz);
    vectors++;
    if (lat !== 21) begin
      miscompares++;
      $display("FAIL onebit_key_latency: got %0d, expected 21", lat);
    end
    run_block(1'b0, B_KEY, B_CT, lat, pt, hz);
    vectors++;
    if (lat !== 21 || pt !== B_PT) begin
      miscompares++;
      $display("FAIL key_overwrite: latency %0d blok %h, expected 21 %h", lat, pt, B_PT);
    end
    run_block(1'b0, B_KEY, B_CT, lat, pt, hz);
    vectors++;
    if (lat !== 11 || pt !== B_PT) begin
      miscompares++;
      $display("FAIL rehit: latency %0d blok %h, expected 11 %h", lat, pt, B_PT);
    end
  endtask

  task automatic test_no_cache;
    int lat; logic [127:0] pt; bit hz;
    for (int k = 0; k < 2; k++) begin
      run_block(1'b1, B_KEY, B_CT, lat, pt, hz);
      vectors++;
      if (lat !== 21 || pt !== B_PT) begin
        miscompares++;
        $display("FAIL nocache_run%0d: latency %0d blok %h, expected 21 %h", k, lat, pt, B_PT);
      end
    end
  endtask

  task automatic test_stall;
    int lat; int seen;
    anahtar = B_KEY;
    sifre   = B_CT;
    g_gecerli = 1'b1;
    @(posedge clk); #1;
    g_gecerli = 1'b0;
    lat = 0;
    while (!c_gecerli && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (c_gecerli !== 1'b1 || blok !== B_PT) begin
      miscompares++;
      $display("FAIL stall_entry: c_gecerli=%b blok=%h, expected 1 %h", c_gecerli, blok, B_PT);
    end
    for (int i = 0; i < 50; i++) begin
      g_gecerli = i[0];
      anahtar   = C1_KEY;
      sifre     = {16{i[7:0]}};
      @(posedge clk); #1;
      vectors++;
      if (blok !== B_PT || c_gecerli !== 1'b1 || hazir !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: blok=%h c_gecerli=%b hazir=%b", i, blok, c_gecerli, hazir);
      end
    end
    g_gecerli = 1'b0;
    c_hazir   = 1'b1;
    @(posedge clk); #1;
    c_hazir = 1'b0;
    vectors++;
    if (hazir !== 1'b1 || c_gecerli !== 1'b0) begin
      miscompares++;
      $display("FAIL consume_return: hazir=%b c_gecerli=%b, expected 1 0", hazir, c_gecerli);
    end
    vectors++;
    if (blok !== B_PT) begin
      miscompares++;
      $display("FAIL blok_retained: got %h, expected %h", blok, B_PT);
    end
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (c_gecerli) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL no_second_accept: c_gecerli seen %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_reset_abort;
    int lat; int seen; logic [127:0] pt; bit hz;
    anahtar = C1_KEY;
    sifre   = C1_CT;
    g_gecerli = 1'b1;
    @(posedge clk); #1;
    g_gecerli = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    vectors++;
    if (hazir !== 1'b1 || c_gecerli !== 1'b0 || blok !== 128'h0) begin
      miscompares++;
      $display("FAIL async_reset: hazir=%b c_gecerli=%b blok=%h, expected 1 0 0", hazir, c_gecerli, blok);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (c_gecerli) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_output: c_gecerli seen %0d cycles, expected 0", seen);
    end
    run_block(1'b0, C1_KEY, C1_CT, lat, pt, hz);
    vectors++;
    if (lat !== 21 || pt !== C1_PT) begin
      miscompares++;
      $display("FAIL resubmit: latency %0d blok %h, expected 21 %h", lat, pt, C1_PT);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [127:0] pt; bit hz;
    logic [127:0] key, ct, exp;
    for (int k = 0; k < 4; k++) begin
      key = k[0] ? C1_KEY : B_KEY;
      ct  = k[0] ? C1_CT  : B_CT;
      exp = k[0] ? C1_PT  : B_PT;
      run_block(1'b0, key, ct, lat, pt, hz);
      vectors++;
      if (lat !== 21 || pt !== exp) begin
        miscompares++;
        $display("FAIL b2b_block%0d: latency %0d blok %h, expected 21 %h", k, lat, pt, exp);
      end
      vectors++;
      if (hz !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hazir%0d: hazir seen high during operation, expected 0", k);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b1;
    anahtar    = '0;
    sifre      = '0;
    g_gecerli  = 1'b0;
    g_gecerli2 = 1'b0;
    c_hazir    = 1'b0;
    c_hazir2   = 1'b0;
    test_reset;
    test_fips_c1;
    test_fips_b;
    test_cache;
    test_no_cache;
    test_stall;
    test_reset_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
